// File: rtl/acoustics_pkg.sv
// Shared types and constants for the hydrophone acquisition path.
package acoustics_pkg;
  localparam int AXIS_DATA_W = 32;

  typedef enum logic {
    PACK_LOW  = 1'b0,
    PACK_HIGH = 1'b1
  } pack_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head; a write into an empty FIFO appears one edge later.
// Caller must only push when not full (or full with pop) and only pop when not empty.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    dout_d   = dout_q;
    // Head only moves when something remains; an emptied FIFO keeps showing its last word.
    if (count_d != '0) begin
      if ((count_q - CW'(pop)) == '0) dout_d = din;
      else                            dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/adc_axis_packer.sv
// Packs sample pairs into 32-bit AXI-Stream words through a small FIFO; head valid one edge after push, full T_READY backpressure, drops flagged in sticky overflow.
// Define FRAME_TLAST_EN to add a frame counter and T_LAST on every FRAME_WORDS-th accepted word.
module adc_axis_packer
  import acoustics_pkg::*;
#(
  parameter  int SAMPLE_W    = 16,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int FRAME_WORDS = 64,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   enable,
  input  logic [SAMPLE_W-1:0]    sample_in,
  input  logic                   sample_valid,
  input  logic                   T_READY,
  output logic [AXIS_DATA_W-1:0] T_DATA,
  output logic                   T_VALID,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [CNT_W-1:0]       fifo_count
`ifdef FRAME_TLAST_EN
  ,
  output logic                   T_LAST
`endif
);
`ifdef FRAME_TLAST_EN
  localparam int FIFO_W = AXIS_DATA_W + 1;
  localparam int FC_W   = $clog2(FRAME_WORDS);
`else
  localparam int FIFO_W = AXIS_DATA_W;
`endif

  pack_state_e         state_q;
  logic [SAMPLE_W-1:0] low_half_q;
  logic                overflow_q, overflow_d;

  logic                push_req, push_acc, drop, pop;
  logic [FIFO_W-1:0]   fifo_din, fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [AXIS_DATA_W-1:0] word;

  assign word     = {sample_in, low_half_q};
  assign pop      = !fifo_empty && T_READY;
  assign push_req = enable && sample_valid && (state_q == PACK_HIGH);
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push_acc = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= PACK_LOW;
      low_half_q <= '0;
    end else if (!enable) begin
      state_q <= PACK_LOW;
    end else if (sample_valid) begin
      case (state_q)
        PACK_LOW: begin
          low_half_q <= sample_in;
          state_q    <= PACK_HIGH;
        end
        PACK_HIGH: state_q <= PACK_LOW;
        default:   state_q <= PACK_LOW;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

`ifdef FRAME_TLAST_EN
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (push_acc) begin
      if (frame_cnt_q == FC_W'(FRAME_WORDS - 1)) frame_cnt_d = '0;
      else                                       frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign fifo_din = {(frame_cnt_q == FC_W'(FRAME_WORDS - 1)), word};
  assign T_LAST   = fifo_dout[AXIS_DATA_W];
`else
  assign fifo_din = word;
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_b),
    .push  (push_acc),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign T_DATA   = fifo_dout[AXIS_DATA_W-1:0];
  assign T_VALID  = !fifo_empty;
  assign overflow = overflow_q;
endmodule
